// File: rtl/scv_vid_capture.sv
// Video line capture: stores DE-qualified pixels into a ring of line buffers and
// posts one descriptor per committed line to a consumer over a RDY/ACK handshake.
module scv_vid_capture #(
  parameter int unsigned PW     = 24,
  parameter int unsigned MAXW   = 256,
  parameter int unsigned NLINES = 2,
  parameter int unsigned LNW    = 9,
  localparam int unsigned AW    = $clog2(MAXW),
  localparam int unsigned SW    = $clog2(NLINES)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ce,
  input  logic          i_en,
  input  logic          i_de,
  input  logic          i_vs,
  input  logic [PW-1:0] i_rgb,
  output logic          o_line_rdy,
  output logic [SW-1:0] o_line_idx,
  output logic [AW:0]   o_line_len,
  output logic [LNW-1:0] o_line_num,
  input  logic          i_line_ack,
  input  logic [SW-1:0] i_rd_line,
  input  logic [AW-1:0] i_rd_addr,
  output logic [PW-1:0] o_rd_data,
  output logic          o_ovf,
  output logic          o_err_long,
  output logic [15:0]   o_frame_cnt
);

  localparam logic [SW:0] CountMax = (SW+1)'(NLINES);
  localparam logic [AW:0] MaxLen   = (AW+1)'(MAXW);

  typedef enum logic [1:0] {StWaitVs, StIdle, StLine, StDrop} state_t;

  state_t         r_state, w_state_nxt;
  logic           r_vs_prev;
  logic [SW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [SW:0]    r_count;
  logic [AW:0]    r_len, w_len_nxt;
  logic [LNW-1:0] r_linenum;
  logic           r_ovf, r_err_long;
  logic [15:0]    r_frame_cnt;
  logic [AW:0]    r_desc_len [NLINES];
  logic [LNW-1:0] r_desc_num [NLINES];
  logic [PW-1:0]  r_mem [NLINES*MAXW];
  logic [PW-1:0]  r_rd_data;

  logic          w_vs_rise, w_ack, w_wr_en, w_commit, w_drop_end, w_set_ovf, w_set_err;
  logic [AW-1:0] w_wr_addr;

  assign w_vs_rise = i_ce & i_vs & ~r_vs_prev;
  assign w_ack     = i_line_ack & (r_count != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_wr_en     = 1'b0;
    w_wr_addr   = '0;
    w_commit    = 1'b0;
    w_drop_end  = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_err   = 1'b0;
    if (!i_en) begin
      w_state_nxt = StWaitVs;
    end else if (i_ce) begin
      // A new frame start discards any partial line.
      if (w_vs_rise) begin
        w_state_nxt = StIdle;
      end else begin
        unique case (r_state)
          StWaitVs: ;
          StIdle: begin
            if (i_de) begin
              if (r_count < CountMax) begin
                w_wr_en     = 1'b1;
                w_len_nxt   = (AW+1)'(1);
                w_state_nxt = StLine;
              end else begin
                w_set_ovf   = 1'b1;
                w_state_nxt = StDrop;
              end
            end
          end
          StLine: begin
            if (i_de) begin
              if (r_len < MaxLen) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_len[AW-1:0];
                w_len_nxt = r_len + (AW+1)'(1);
              end else begin
                w_set_err = 1'b1;
              end
            end else begin
              w_commit    = 1'b1;
              w_state_nxt = StIdle;
            end
          end
          StDrop: begin
            if (!i_de) begin
              w_drop_end  = 1'b1;
              w_state_nxt = StIdle;
            end
          end
          default: w_state_nxt = StWaitVs;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StWaitVs;
      r_vs_prev   <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_linenum   <= '0;
      r_ovf       <= 1'b0;
      r_err_long  <= 1'b0;
      r_frame_cnt <= '0;
      for (int i = 0; i < NLINES; i++) begin
        r_desc_len[i] <= '0;
        r_desc_num[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      if (i_ce) r_vs_prev <= i_vs;
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_err) r_err_long <= 1'b1;
      if (w_vs_rise) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_vs_rise) r_linenum <= '0;
      else if (w_commit || w_drop_end) r_linenum <= r_linenum + LNW'(1);
      if (w_commit) begin
        r_desc_len[r_wr_ptr] <= r_len;
        r_desc_num[r_wr_ptr] <= r_linenum;
        r_wr_ptr             <= r_wr_ptr + SW'(1);
      end
      if (w_ack) r_rd_ptr <= r_rd_ptr + SW'(1);
      if (w_commit && !w_ack) r_count <= r_count + (SW+1)'(1);
      else if (!w_commit && w_ack) r_count <= r_count - (SW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[{r_wr_ptr, w_wr_addr}] <= i_rgb;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rd_data <= '0;
    else          r_rd_data <= r_mem[{i_rd_line, i_rd_addr}];
  end

  assign o_line_rdy  = (r_count != '0);
  assign o_line_idx  = r_rd_ptr;
  assign o_line_len  = r_desc_len[r_rd_ptr];
  assign o_line_num  = r_desc_num[r_rd_ptr];
  assign o_rd_data   = r_rd_data;
  assign o_ovf       = r_ovf;
  assign o_err_long  = r_err_long;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_scv_vid_capture.sv
// Self-checking bench for scv_vid_capture: vector table, directed corner cases and
// randomized traffic compared against a queue-based reference model.
module tb_scv_vid_capture;

  localparam int PW = 24, MAXW = 256, NLINES = 2, LNW = 9;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ce = 0, en = 0, de = 0, vs = 0, ack = 0;
  logic [23:0] rgb = '0;
  logic [0:0]  rd_line = '0;
  logic [7:0]  rd_addr = '0;
  logic        line_rdy, ovf, err_long;
  logic [0:0]  line_idx;
  logic [8:0]  line_len;
  logic [8:0]  line_num;
  logic [23:0] rd_data;
  logic [15:0] frame_cnt;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  scv_vid_capture #(.PW(PW), .MAXW(MAXW), .NLINES(NLINES), .LNW(LNW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_en(en), .i_de(de), .i_vs(vs), .i_rgb(rgb),
    .o_line_rdy(line_rdy), .o_line_idx(line_idx), .o_line_len(line_len),
    .o_line_num(line_num), .i_line_ack(ack), .i_rd_line(rd_line), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_ovf(ovf), .o_err_long(err_long), .o_frame_cnt(frame_cnt)
  );

  // Reference model: committed lines as a FIFO of descriptors, a flat pixel store.
  typedef struct {int slot; int len; int num;} desc_t;
  localparam int MWait = 0, MIdle = 1, MCap = 2, MDrop = 3;
  desc_t       mq[$];
  int          m_mode, m_len, m_slot, m_frame, m_num;
  bit          m_vs_prev, m_ovf, m_err, m_rd_valid;
  logic [23:0] m_mem [NLINES*MAXW];
  logic [23:0] m_rd;

  task automatic model_reset();
    mq.delete();
    m_mode = MWait; m_len = 0; m_slot = 0; m_frame = 0; m_num = 0;
    m_vs_prev = 0; m_ovf = 0; m_err = 0; m_rd_valid = 0;
  endtask

  task automatic model_edge();
    int    pre_cnt;
    bit    commit, rise;
    desc_t d;
    pre_cnt = mq.size();
    commit  = 0;
    m_rd_valid = 0;
    if (pre_cnt > 0)
      m_rd_valid = (int'(rd_line) == mq[0].slot) && (int'(rd_addr) < mq[0].len);
    m_rd = m_mem[int'(rd_line) * MAXW + int'(rd_addr)];
    if (ce) begin
      rise = vs && !m_vs_prev;
      m_vs_prev = vs;
      if (rise) begin
        m_frame = (m_frame + 1) % 65536;
        m_num = 0;
      end
      if (!en) m_mode = MWait;
      else if (rise) m_mode = MIdle;
      else if (m_mode == MIdle && de) begin
        if (pre_cnt < NLINES) begin
          m_mem[m_slot * MAXW] = rgb; m_len = 1; m_mode = MCap;
        end else begin
          m_ovf = 1; m_mode = MDrop;
        end
      end else if (m_mode == MCap && de) begin
        if (m_len < MAXW) begin
          m_mem[m_slot * MAXW + m_len] = rgb; m_len++;
        end else m_err = 1;
      end else if (m_mode == MCap) begin
        d.slot = m_slot; d.len = m_len; d.num = m_num; commit = 1;
        m_slot = (m_slot + 1) % NLINES;
        m_num = (m_num + 1) % (1 << LNW);
        m_mode = MIdle;
      end else if (m_mode == MDrop && !de) begin
        m_num = (m_num + 1) % (1 << LNW);
        m_mode = MIdle;
      end
    end else if (!en) m_mode = MWait;
    if (ack && pre_cnt > 0) void'(mq.pop_front());
    if (commit) mq.push_back(d);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    cmp("rdy", 32'(line_rdy), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      cmp("idx", 32'(line_idx), mq[0].slot);
      cmp("len", 32'(line_len), mq[0].len);
      cmp("num", 32'(line_num), mq[0].num);
    end
    cmp("ovf", 32'(ovf), 32'(m_ovf));
    cmp("err_long", 32'(err_long), 32'(m_err));
    cmp("frame_cnt", 32'(frame_cnt), m_frame);
    if (m_rd_valid) cmp("rd_data", 32'(rd_data), 32'(m_rd));
  endtask

  task automatic step(input bit c, input bit e, input bit d, input bit v,
                      input logic [23:0] p, input bit a);
    ce = c; en = e; de = d; vs = v; rgb = p; ack = a;
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    ce = 0; en = 0; de = 0; vs = 0; ack = 0; rgb = '0;
    #3 rst_n = 1'b0;
    model_reset();
    #4;
    cmp("rst_rdy", 32'(line_rdy), 0);
    cmp("rst_idx", 32'(line_idx), 0);
    cmp("rst_len", 32'(line_len), 0);
    cmp("rst_num", 32'(line_num), 0);
    cmp("rst_rd_data", 32'(rd_data), 0);
    cmp("rst_ovf", 32'(ovf), 0);
    cmp("rst_err", 32'(err_long), 0);
    cmp("rst_frame", 32'(frame_cnt), 0);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic vs_pulse();
    step(1, 1, 0, 1, 24'h0, 0);
    step(1, 1, 0, 0, 24'h0, 0);
  endtask

  task automatic send_line(input int n, input int base);
    for (int i = 0; i < n; i++) step(1, 1, 1, 0, 24'(base + i), 0);
    step(1, 1, 0, 0, 24'h0, 0);
  endtask

  typedef struct {
    bit ce, en, de, vs; logic [23:0] rgb; bit ack;
    bit e_rdy; int e_len; int e_num; int e_frame;
  } vec_t;

  initial begin
    vec_t vt[9];
    bit   de_run;
    vt[0] = '{1, 1, 0, 1, 24'h0,   0, 0, 0, 0, 1};
    vt[1] = '{1, 1, 0, 0, 24'h0,   0, 0, 0, 0, 1};
    vt[2] = '{1, 1, 1, 0, 24'h0a,  0, 0, 0, 0, 1};
    vt[3] = '{0, 1, 0, 0, 24'hee,  0, 0, 0, 0, 1};
    vt[4] = '{1, 1, 1, 0, 24'h0b,  0, 0, 0, 0, 1};
    vt[5] = '{1, 1, 1, 0, 24'h0c,  0, 0, 0, 0, 1};
    vt[6] = '{1, 1, 0, 0, 24'h0,   0, 1, 3, 0, 1};
    vt[7] = '{1, 1, 0, 0, 24'h0,   1, 0, 0, 0, 1};
    vt[8] = '{1, 1, 0, 1, 24'h0,   0, 0, 0, 0, 2};

    do_reset();
    foreach (vt[i]) begin
      step(vt[i].ce, vt[i].en, vt[i].de, vt[i].vs, vt[i].rgb, vt[i].ack);
      cmp($sformatf("vec%0d_rdy", i), 32'(line_rdy), 32'(vt[i].e_rdy));
      cmp($sformatf("vec%0d_frame", i), 32'(frame_cnt), vt[i].e_frame);
      if (vt[i].e_rdy) begin
        cmp($sformatf("vec%0d_len", i), 32'(line_len), vt[i].e_len);
        cmp($sformatf("vec%0d_num", i), 32'(line_num), vt[i].e_num);
      end
    end

    // T1: basic line capture and readout
    do_reset();
    vs_pulse();
    send_line(10, 0);
    cmp("t1_rdy", 32'(line_rdy), 1);
    cmp("t1_idx", 32'(line_idx), 0);
    cmp("t1_len", 32'(line_len), 10);
    cmp("t1_num", 32'(line_num), 0);
    rd_line = 1'b0; rd_addr = 8'd5;
    step(0, 1, 0, 0, 24'h0, 0);
    cmp("t1_rd_data", 32'(rd_data), 32'h5);

    // T2: ring full drops a line, numbering continues
    do_reset();
    vs_pulse();
    send_line(3, 100);
    send_line(3, 200);
    send_line(3, 300);
    cmp("t2_ovf", 32'(ovf), 1);
    cmp("t2_idx", 32'(line_idx), 0);
    cmp("t2_num", 32'(line_num), 0);
    step(1, 1, 0, 0, 24'h0, 1);
    cmp("t2_num_after_ack", 32'(line_num), 1);
    step(1, 1, 0, 0, 24'h0, 1);
    cmp("t2_rdy_empty", 32'(line_rdy), 0);
    send_line(2, 400);
    cmp("t2_next_num", 32'(line_num), 3);
    cmp("t2_next_idx", 32'(line_idx), 0);

    // T3: overlong line saturates
    do_reset();
    vs_pulse();
    send_line(300, 0);
    cmp("t3_len", 32'(line_len), 256);
    cmp("t3_err", 32'(err_long), 1);
    rd_line = 1'b0; rd_addr = 8'd255;
    step(0, 1, 0, 0, 24'h0, 0);
    cmp("t3_rd_data", 32'(rd_data), 32'd255);

    // T4: VS mid-line discards the partial line
    do_reset();
    vs_pulse();
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 24'(i), 0);
    step(1, 1, 1, 1, 24'h4, 0);
    cmp("t4_frame", 32'(frame_cnt), 2);
    step(1, 1, 0, 1, 24'h0, 0);
    step(1, 1, 0, 0, 24'h0, 0);
    cmp("t4_no_commit", 32'(line_rdy), 0);
    send_line(2, 50);
    cmp("t4_num", 32'(line_num), 0);
    cmp("t4_len", 32'(line_len), 2);

    // T5: commit and ACK on the same clock
    do_reset();
    vs_pulse();
    send_line(2, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 24'(i), 0);
    step(1, 1, 0, 0, 24'h0, 1);
    cmp("t5_rdy", 32'(line_rdy), 1);
    cmp("t5_idx", 32'(line_idx), 1);
    cmp("t5_len", 32'(line_len), 3);
    cmp("t5_num", 32'(line_num), 1);

    // T6: EN drop aborts and re-arms on VS; reset mid-frame
    do_reset();
    vs_pulse();
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 24'(i), 0);
    step(0, 0, 1, 0, 24'h0, 0);
    send_line(4, 0);
    cmp("t6_ignored", 32'(line_rdy), 0);
    vs_pulse();
    send_line(2, 7);
    cmp("t6_rdy", 32'(line_rdy), 1);
    cmp("t6_num", 32'(line_num), 0);
    cmp("t6_frame", 32'(frame_cnt), 2);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 24'(i), 0);
    do_reset();

    // Randomized traffic
    de_run = 0;
    for (int n = 0; n < 4000; n++) begin
      bit c, e, v, a;
      c = ($urandom_range(0, 3) != 0);
      e = ($urandom_range(0, 149) != 0);
      v = ($urandom_range(0, 119) == 0);
      a = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) de_run = ~de_run;
      if (mq.size() > 0) begin
        rd_line = 1'(mq[0].slot);
        rd_addr = 8'($urandom_range(0, mq[0].len - 1));
      end else begin
        rd_line = 1'($urandom);
        rd_addr = 8'($urandom);
      end
      step(c, e, de_run, v, 24'($urandom), a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
